// File: rtl/mul_issue_ctrl.sv
// Purpose : issue sequencer for the shared non-pipelined multiplier; round-robin
//           arbitration of two issue slots, one op in flight, one-entry result buffer.
// Latency : request handshake to RespValid = 2 + multiplier latency cycles.
// Backpr. : both Req*Ready low outside IDLE; result held in HOLD until RespReady or Flush.
//
// Ports
//   Clk, Rest             clock, synchronous active-high reset
//   Flush                 kill the op in flight or in the result buffer
//   Req{0,1}*             request slots: Valid/Ready handshake, Op, Src1, Src2, Dest
//   MulAbleValue/MulOp/   start pulse and registered operands to the multiplier
//   MulSrc1/MulSrc2
//   MulProduct(Valid)     product return from the multiplier
//   Resp*                 result buffer: Valid/Ready, Data, Dest, Port
//   TimeoutErr            sticky: multiplier did not answer within MAX_WAIT
module mul_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int OPW      = 8,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             Flush,

    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [OPW-1:0]   Req0Op,
    input  logic [WIDTH-1:0] Req0Src1,
    input  logic [WIDTH-1:0] Req0Src2,
    input  logic [AW-1:0]    Req0Dest,

    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [OPW-1:0]   Req1Op,
    input  logic [WIDTH-1:0] Req1Src1,
    input  logic [WIDTH-1:0] Req1Src2,
    input  logic [AW-1:0]    Req1Dest,

    output logic             MulAbleValue,
    output logic [OPW-1:0]   MulOp,
    output logic [WIDTH-1:0] MulSrc1,
    output logic [WIDTH-1:0] MulSrc2,
    input  logic [WIDTH-1:0] MulProduct,
    input  logic             MulProductValid,

    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] RespData,
    output logic [AW-1:0]    RespDest,
    output logic             RespPort,

    output logic             TimeoutErr
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;   // 1: slot 1 was granted most recently
    logic             kill_q,       kill_d;         // op in flight was flushed, drop its product
    logic [CW-1:0]    wait_cnt_q,   wait_cnt_d;
    logic             start_q,      start_d;
    logic [OPW-1:0]   op_q,         op_d;
    logic [WIDTH-1:0] src1_q,       src1_d;
    logic [WIDTH-1:0] src2_q,       src2_d;
    logic [AW-1:0]    dest_q,       dest_d;
    logic             port_q,       port_d;
    logic             resp_vld_q,   resp_vld_d;
    logic [WIDTH-1:0] resp_data_q,  resp_data_d;
    logic             timeout_q,    timeout_d;

    logic grant0;
    logic grant1;
    logic accept_ok;
    logic hs0;
    logic hs1;

    // ------------------------------------------------------------------
    // Round-robin arbitration. A lone requester always wins; with both
    // valid the slot that was not granted last time wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (Req0Valid && Req1Valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = Req0Valid;
            grant1 = Req1Valid;
        end
    end

    // Ready is also masked by Rest so nothing appears accepted during reset.
    assign accept_ok = (state_q == ST_IDLE) && !Flush && !Rest;
    assign Req0Ready = grant0 && accept_ok;
    assign Req1Ready = grant1 && accept_ok;
    assign hs0       = Req0Valid && Req0Ready;
    assign hs1       = Req1Valid && Req1Ready;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        kill_d       = kill_q;
        wait_cnt_d   = wait_cnt_q;
        start_d      = 1'b0;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dest_d       = dest_q;
        port_d       = port_q;
        resp_vld_d   = resp_vld_q;
        resp_data_d  = resp_data_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (hs0 || hs1) begin
                    op_d         = hs1 ? Req1Op   : Req0Op;
                    src1_d       = hs1 ? Req1Src1 : Req0Src1;
                    src2_d       = hs1 ? Req1Src2 : Req0Src2;
                    dest_d       = hs1 ? Req1Dest : Req0Dest;
                    port_d       = hs1;
                    last_grant_d = hs1;
                    start_d      = 1'b1;
                    wait_cnt_d   = '0;
                    kill_d       = 1'b0;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (MulProductValid) begin
                    // A product for a flushed op (earlier or this cycle) is dropped.
                    if (kill_q || Flush) begin
                        kill_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        resp_vld_d  = 1'b1;
                        resp_data_d = MulProduct;
                        state_d     = ST_HOLD;
                    end
                end else if (wait_cnt_q == CW'(MAX_WAIT)) begin
                    timeout_d = 1'b1;
                    kill_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    // The multiplier cannot be aborted, so a flush only marks the
                    // op; we still wait for its product before going idle.
                    if (Flush) begin
                        kill_d = 1'b1;
                    end
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
            end

            ST_HOLD: begin
                // Flush and RespReady both empty the buffer, so flush winning
                // just means the result is discarded instead of delivered.
                if (Flush || RespReady) begin
                    resp_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            kill_q       <= 1'b0;
            wait_cnt_q   <= '0;
            start_q      <= 1'b0;
            op_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dest_q       <= '0;
            port_q       <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_data_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            kill_q       <= kill_d;
            wait_cnt_q   <= wait_cnt_d;
            start_q      <= start_d;
            op_q         <= op_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dest_q       <= dest_d;
            port_q       <= port_d;
            resp_vld_q   <= resp_vld_d;
            resp_data_q  <= resp_data_d;
            timeout_q    <= timeout_d;
        end
    end

    // Operands, dest and port only change on a handshake in IDLE, so they stay
    // stable for the whole multiply and the following HOLD.
    assign MulAbleValue = start_q;
    assign MulOp        = op_q;
    assign MulSrc1      = src1_q;
    assign MulSrc2      = src2_q;
    assign RespValid    = resp_vld_q;
    assign RespData     = resp_data_q;
    assign RespDest     = dest_q;
    assign RespPort     = port_q;
    assign TimeoutErr   = timeout_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Purpose : self-checking bench for mul_issue_ctrl with a behavioural multiplier.
// Latency : multiplier answers mul_lat cycles after the start pulse (or never when muted).
// Backpr. : bench drives RespReady from tables, hand sequences and $urandom.
module tb_mul_issue_ctrl;

    localparam int MAX_WAIT = 15;

    logic        Clk = 1'b0;
    logic        Rest = 1'b1;
    logic        Flush = 1'b0;
    logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic        Req0Ready, Req1Ready;
    logic [7:0]  Req0Op = '0, Req1Op = '0;
    logic [31:0] Req0Src1 = '0, Req0Src2 = '0, Req1Src1 = '0, Req1Src2 = '0;
    logic [4:0]  Req0Dest = '0, Req1Dest = '0;
    logic        MulAbleValue;
    logic [7:0]  MulOp;
    logic [31:0] MulSrc1, MulSrc2;
    logic [31:0] MulProduct = '0;
    logic        MulProductValid = 1'b0;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [31:0] RespData;
    logic [4:0]  RespDest;
    logic        RespPort;
    logic        TimeoutErr;

    mul_issue_ctrl dut (
        .Clk(Clk), .Rest(Rest), .Flush(Flush),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op(Req0Op),
        .Req0Src1(Req0Src1), .Req0Src2(Req0Src2), .Req0Dest(Req0Dest),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op(Req1Op),
        .Req1Src1(Req1Src1), .Req1Src2(Req1Src2), .Req1Dest(Req1Dest),
        .MulAbleValue(MulAbleValue), .MulOp(MulOp), .MulSrc1(MulSrc1), .MulSrc2(MulSrc2),
        .MulProduct(MulProduct), .MulProductValid(MulProductValid),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .RespDest(RespDest), .RespPort(RespPort), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    // Behavioural multiplier: product valid mul_lat cycles after the start pulse.
    int          mul_lat  = 4;
    bit          mul_mute = 1'b0;
    int          mul_cnt  = 0;
    logic [31:0] mul_res  = '0;

    always begin
        @(negedge Clk);
        if (MulAbleValue === 1'b1) begin
            mul_cnt = mul_lat;
            mul_res = MulSrc1 * MulSrc2;
        end
        @(posedge Clk);
        #1;
        MulProductValid = 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0 && !mul_mute) begin
                MulProductValid = 1'b1;
                MulProduct      = mul_res;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        Rest = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0; Flush = 1'b0; RespReady = 1'b0;
        repeat (6) adv();
        Rest = 1'b0;
    endtask

    typedef struct {
        bit v0, v1, fl, rr;
        bit r0, r1, st, rv;
    } vec_t;
    vec_t tbl[17];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        bit          port;
    } rsp_t;
    rsp_t        buf_q[$];
    rsp_t        rs;
    int          age;
    bit          killed, last_m, idle, e0, e1;
    logic [31:0] c_a, c_b;
    logic [7:0]  c_op;
    logic [4:0]  c_dest;
    bit          c_port;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle script, lat 4; slot0 = 7*-3 ->5, slot1 = 100*6 ->9.
        //          v0 v1 fl rr   r0 r1 st rv
        tbl[0]  = '{1, 1, 0, 1,   1, 0, 0, 0};  // both valid, slot0 first
        tbl[1]  = '{1, 1, 0, 1,   0, 0, 1, 0};  // start pulse
        tbl[2]  = '{1, 1, 0, 1,   0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1,   0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 1,   0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 1,   0, 0, 0, 0};  // product arrives
        tbl[6]  = '{1, 1, 0, 0,   0, 0, 0, 1};  // handshake + 6, held
        tbl[7]  = '{1, 1, 0, 1,   0, 0, 0, 1};  // accepted
        tbl[8]  = '{1, 1, 1, 1,   0, 0, 0, 0};  // flush blocks ready in idle
        tbl[9]  = '{1, 1, 0, 1,   0, 1, 0, 0};  // round robin -> slot1
        tbl[10] = '{0, 0, 0, 1,   0, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 1,   0, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 1,   0, 0, 0, 0};  // flush 2 cycles after start
        tbl[13] = '{0, 0, 0, 1,   0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1,   0, 0, 0, 0};  // killed product dropped
        tbl[15] = '{0, 1, 0, 1,   0, 1, 0, 0};  // lone requester wins
        tbl[16] = '{1, 0, 0, 1,   0, 0, 1, 0};  // busy: slot0 not ready

        // ---------------- reset state (valids high to test masking) ----------------
        Req0Valid = 1'b1; Req1Valid = 1'b1;
        adv(); adv();
        settle();
        chk("rst_rdy0", Req0Ready, 0);    chk("rst_rdy1", Req1Ready, 0);
        chk("rst_start", MulAbleValue, 0); chk("rst_resp_vld", RespValid, 0);
        chk("rst_data", RespData, 0);      chk("rst_src1", MulSrc1, 0);
        chk("rst_timeout", TimeoutErr, 0);
        adv();
        Rest = 1'b0; Req0Valid = 1'b0; Req1Valid = 1'b0;
        adv();

        // ---------------- T1 single op, then T3 held result ----------------
        Req0Valid = 1'b1; Req0Src1 = 32'd7; Req0Src2 = 32'hFFFF_FFFD; Req0Dest = 5'd5;
        Req0Op = 8'h21; RespReady = 1'b0;
        settle();
        chk("t1_rdy0", Req0Ready, 1); chk("t1_rdy1", Req1Ready, 0);
        adv();
        Req0Valid = 1'b0;
        settle();
        chk("t1_start", MulAbleValue, 1); chk("t1_src1", MulSrc1, 32'd7);
        chk("t1_src2", MulSrc2, 32'hFFFF_FFFD); chk("t1_op", MulOp, 8'h21);
        adv();
        for (int k = 2; k <= 5; k++) begin
            settle();
            chk("t1_start_once", MulAbleValue, 0); chk("t1_no_early_resp", RespValid, 0);
            chk("t1_src_stable", MulSrc1, 32'd7);
            adv();
        end
        Req0Valid = 1'b1; Req1Valid = 1'b1;
        Req1Src1 = 32'd100; Req1Src2 = 32'd6; Req1Dest = 5'd9; Req1Op = 8'h22;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t3_resp_vld", RespValid, 1); chk("t3_data", RespData, 32'hFFFF_FFEB);
            chk("t3_dest", RespDest, 5'd5);   chk("t3_port", RespPort, 0);
            chk("t3_rdy0", Req0Ready, 0);     chk("t3_rdy1", Req1Ready, 0);
            adv();
        end
        RespReady = 1'b1;
        settle();
        chk("t3_accept_vld", RespValid, 1);
        adv();
        settle();
        chk("t3_idle_vld", RespValid, 0); chk("t3_idle_rdy0", Req0Ready, 0);
        chk("t3_idle_rdy1", Req1Ready, 1);
        adv();

        // ---------------- T6 reset while busy ----------------
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        settle();
        chk("t6_start", MulAbleValue, 1);
        adv();
        Rest = 1'b1;
        adv();
        Rest = 1'b0;
        settle();
        chk("t6_start", MulAbleValue, 0); chk("t6_resp_vld", RespValid, 0);
        chk("t6_src1", MulSrc1, 0);       chk("t6_op", MulOp, 0);
        chk("t6_data", RespData, 0);      chk("t6_dest", RespDest, 0);
        chk("t6_port", RespPort, 0);      chk("t6_timeout", TimeoutErr, 0);
        adv();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t6_late_product_ignored", RespValid, 0);
            adv();
        end

        // ---------------- T2/T4 table ----------------
        do_reset();
        mul_lat = 4;
        for (int i = 0; i < 17; i++) begin
            Req0Valid = tbl[i].v0; Req1Valid = tbl[i].v1;
            Flush = tbl[i].fl;     RespReady = tbl[i].rr;
            settle();
            chk($sformatf("tbl%0d_rdy0", i), Req0Ready, tbl[i].r0);
            chk($sformatf("tbl%0d_rdy1", i), Req1Ready, tbl[i].r1);
            chk($sformatf("tbl%0d_start", i), MulAbleValue, tbl[i].st);
            chk($sformatf("tbl%0d_resp_vld", i), RespValid, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("tbl%0d_data", i), RespData, 32'hFFFF_FFEB);
            adv();
        end
        Flush = 1'b0;

        // ---------------- T5 timeout ----------------
        do_reset();
        mul_mute = 1'b1;
        Req0Valid = 1'b1;
        settle();
        chk("t5_rdy0", Req0Ready, 1);
        adv();
        Req0Valid = 1'b0;
        for (int k = 1; k <= MAX_WAIT + 1; k++) begin
            settle();
            chk($sformatf("t5_no_timeout_c%0d", k), TimeoutErr, 0);
            adv();
        end
        Req0Valid = 1'b1;
        settle();
        chk("t5_timeout", TimeoutErr, 1); chk("t5_idle_rdy0", Req0Ready, 1);
        adv();
        Req0Valid = 1'b0;
        settle();
        chk("t5_sticky", TimeoutErr, 1); chk("t5_restart", MulAbleValue, 1);
        adv();
        do_reset();
        mul_mute = 1'b0;
        settle();
        chk("t5_cleared_by_reset", TimeoutErr, 0);
        adv();

        // ---------------- randomized run against transaction model ----------------
        age = -1; killed = 1'b0; last_m = 1'b1; buf_q.delete();
        for (int n = 0; n < 1500; n++) begin
            Req0Valid = ($urandom_range(0, 2) != 0);
            Req1Valid = ($urandom_range(0, 2) != 0);
            Req0Src1 = $urandom; Req0Src2 = $urandom; Req0Dest = 5'($urandom); Req0Op = 8'($urandom);
            Req1Src1 = $urandom; Req1Src2 = $urandom; Req1Dest = 5'($urandom); Req1Op = 8'($urandom);
            Flush     = ($urandom_range(0, 24) == 0);
            RespReady = ($urandom_range(0, 3) != 0);
            mul_lat   = $urandom_range(1, 6);
            settle();
            idle = (age < 0) && (buf_q.size() == 0);
            e0 = idle && !Flush && Req0Valid && (!Req1Valid || last_m);
            e1 = idle && !Flush && Req1Valid && (!Req0Valid || !last_m);
            chk("rnd_rdy0", Req0Ready, e0);
            chk("rnd_rdy1", Req1Ready, e1);
            chk("rnd_start", MulAbleValue, (age == 0));
            chk("rnd_resp_vld", RespValid, (buf_q.size() != 0));
            chk("rnd_timeout", TimeoutErr, 0);
            if (buf_q.size() != 0) begin
                chk("rnd_data", RespData, buf_q[0].data);
                chk("rnd_dest", RespDest, buf_q[0].dest);
                chk("rnd_port", RespPort, buf_q[0].port);
            end
            if (age == 0) begin
                chk("rnd_src1", MulSrc1, c_a); chk("rnd_src2", MulSrc2, c_b);
                chk("rnd_op", MulOp, c_op);
            end
            if (e0 || e1) begin
                c_a    = e1 ? Req1Src1 : Req0Src1;
                c_b    = e1 ? Req1Src2 : Req0Src2;
                c_op   = e1 ? Req1Op   : Req0Op;
                c_dest = e1 ? Req1Dest : Req0Dest;
                c_port = e1;
                last_m = e1;
                age    = 0;
                killed = 1'b0;
            end else if (age >= 0) begin
                if (MulProductValid) begin
                    if (!killed && !Flush) begin
                        rs.data = c_a * c_b; rs.dest = c_dest; rs.port = c_port;
                        buf_q.push_back(rs);
                    end
                    age    = -1;
                    killed = 1'b0;
                end else begin
                    if (Flush) killed = 1'b1;
                    age++;
                end
            end else if (buf_q.size() != 0 && (Flush || RespReady)) begin
                void'(buf_q.pop_front());
            end
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
